// File: rtl/da_wave_ctrl.sv
// da_wave_ctrl: DA waveform sequencer.
// A phase accumulator produces the waveform ROM read address. Returned samples
// are scaled by a programmable amplitude and driven to the AD9708 pins.
// Playback is continuous or a burst of N periods. New frequency and amplitude
// values take effect only at a period boundary (phase wrap).
// Optional build macro DA_WAVE_DITHER_EN adds LFSR dither to the address
// truncation. Without the macro the address is plain truncation of the phase.
module da_wave_ctrl #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [7:0]         cfg_amp,
    input  logic [15:0]        cfg_cycles,
    input  logic               start,
    input  logic               stop,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [7:0]         rd_data,
    output logic               da_clk,
    output logic [7:0]         da_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   freq_q, sh_freq_q;
    logic [7:0]           amp_q, sh_amp_q;
    logic [15:0]          cyc_q, sh_cyc_q;
    logic [15:0]          per_cnt_q;
    logic [1:0]           drain_cnt_q;
    logic                 pend_q;
    logic                 stop_req_q;
    logic                 done_q;
    logic [PHASE_W:0]     phase_sum;
    logic                 wrap;
    logic                 period_end;
    logic                 issue;

    // Datapath pipeline: a valid tag and the amplitude in force at issue time
    // travel alongside the ROM read, so a period boundary never rescales
    // samples that are still in flight.
    logic [ROM_LAT-1:0]       vld_pipe_q;
    logic [ROM_LAT-1:0][7:0]  amp_pipe_q;
    logic [7:0]               da_q;
    logic signed [8:0]        smp_s;
    logic signed [16:0]       smp_x, amp_x, prod;

    assign phase_sum  = {1'b0, phase_q} + {1'b0, freq_q};
    assign phase_d    = phase_sum[PHASE_W-1:0];
    assign wrap       = phase_sum[PHASE_W];
    assign issue      = (state_q == RUN);
    // A burst ends on the wrap that completes the programmed period count;
    // a pending stop also waits for a wrap so the last period is whole.
    assign period_end = wrap && (((cyc_q != 16'd0) && (per_cnt_q + 16'd1 == cyc_q)) || stop_req_q);

`ifdef DA_WAVE_DITHER_EN
    localparam int DSH = PHASE_W - ADDR_W - 8;
    logic [7:0]         lfsr_q;
    logic [PHASE_W-1:0] dith_phase;
    // Dither lands just below the address bits, so it moves the address by at most +1
    assign dith_phase = phase_q + (PHASE_W'(lfsr_q) << DSH);
    assign rd_addr    = issue ? ADDR_W'(dith_phase >> (PHASE_W - ADDR_W)) : '0;
`else
    assign rd_addr    = phase_q[PHASE_W-1 -: ADDR_W];
`endif

    assign cfg_ready = ~pend_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign da_clk    = ~sys_clk;
    assign da_data   = da_q;

    // Control FSM: config shadowing, phase accumulation, period counting, drain
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            freq_q      <= '0;
            amp_q       <= '0;
            cyc_q       <= '0;
            sh_freq_q   <= '0;
            sh_amp_q    <= '0;
            sh_cyc_q    <= '0;
            per_cnt_q   <= '0;
            drain_cnt_q <= '0;
            pend_q      <= 1'b0;
            stop_req_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef DA_WAVE_DITHER_EN
            lfsr_q      <= 8'h01;
`endif
        end else begin
            done_q <= 1'b0;
            // accept and transfer are exclusive: one needs pend_q low, the other high
            if (cfg_valid && !pend_q) begin
                sh_freq_q <= cfg_freq;
                sh_amp_q  <= cfg_amp;
                sh_cyc_q  <= cfg_cycles;
                pend_q    <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    if (pend_q) begin
                        freq_q <= sh_freq_q;
                        amp_q  <= sh_amp_q;
                        cyc_q  <= sh_cyc_q;
                        pend_q <= 1'b0;
                    end
                    if (start && !stop) begin
                        state_q    <= RUN;
                        per_cnt_q  <= '0;
                        stop_req_q <= 1'b0;
                    end
                end
                RUN: begin
`ifdef DA_WAVE_DITHER_EN
                    lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                    phase_q <= phase_d;
                    if (stop)
                        stop_req_q <= 1'b1;
                    if (wrap) begin
                        per_cnt_q <= per_cnt_q + 16'd1;
                        if (pend_q) begin
                            freq_q <= sh_freq_q;
                            amp_q  <= sh_amp_q;
                            cyc_q  <= sh_cyc_q;
                            pend_q <= 1'b0;
                        end
                    end
                    if (period_end) begin
                        state_q     <= DRAIN;
                        phase_q     <= '0;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    phase_q <= '0;
                    if (drain_cnt_q == 2'(ROM_LAT)) begin
                        state_q    <= IDLE;
                        done_q     <= 1'b1;
                        stop_req_q <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign smp_s = $signed({1'b0, rd_data}) - 9'sd128;
    assign smp_x = {{8{smp_s[8]}}, smp_s};
    assign amp_x = {9'b0, amp_pipe_q[ROM_LAT-1]};
    assign prod  = smp_x * amp_x;

    // Align ROM data with its issue tag, then scale around mid-scale 8'h80
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            amp_pipe_q <= '0;
            da_q       <= 8'h80;
        end else begin
            vld_pipe_q[0] <= issue;
            amp_pipe_q[0] <= amp_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                amp_pipe_q[k] <= amp_pipe_q[k-1];
            end
            // arithmetic shift floors; 128 + floor(p/256) is always 0..254
            da_q <= vld_pipe_q[ROM_LAT-1] ? 8'((prod >>> 8) + 17'sd128) : 8'h80;
        end
    end

endmodule

// File: tb/tb_da_wave_ctrl.sv
// Testbench for da_wave_ctrl: directed stimulus, a cycle-level reference model
// and literal expectations for the hand-computed cases.
module tb_da_wave_ctrl;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst, cfg_valid, cfg_ready, start, stop, da_clk, busy, done;
    logic [31:0] cfg_freq;
    logic [7:0]  cfg_amp, rd_addr, rd_data, da_data;
    logic [15:0] cfg_cycles;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    da_wave_ctrl #(.PHASE_W(32), .ADDR_W(8), .ROM_LAT(LAT)) dut (
        .sys_clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_amp(cfg_amp), .cfg_cycles(cfg_cycles),
        .start(start), .stop(stop), .rd_addr(rd_addr), .rd_data(rd_data),
        .da_clk(da_clk), .da_data(da_data), .busy(busy), .done(done)
    );

    // ROM with LAT cycles of read latency
    logic [7:0] rom [256];
    logic [7:0] rom_pipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) rom_pipe[k] <= rom_pipe[k-1];
        rom_pipe[0] <= rom[rd_addr];
    end
    assign rd_data = rom_pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int scale(input logic [7:0] d, input logic [7:0] a);
        int v;
        v = (int'(d) - 128) * int'(a);
        if (v >= 0) return 128 + v / 256;
        return 128 - ((-v + 255) / 256);
    endfunction

    // ---------------- reference model ----------------
    int          m_st;            // 0 idle, 1 run, 2 drain
    logic [31:0] m_ph, m_freq, s_freq;
    logic [7:0]  m_amp, s_amp;
    logic [15:0] m_cyc, s_cyc, m_cnt;
    bit          m_pend, m_sreq, m_done;
    int          m_left;
    bit          h_v [LAT+1];
    logic [7:0]  h_a [LAT+1];
    logic [7:0]  h_m [LAT+1];

    always @(posedge clk) begin
        longint sum;
        bit     acc, wrap, fin;
        if (rst) begin
            m_st = 0; m_ph = 0; m_freq = 0; m_amp = 0; m_cyc = 0; m_cnt = 0;
            s_freq = 0; s_amp = 0; s_cyc = 0;
            m_pend = 0; m_sreq = 0; m_done = 0; m_left = 0;
            for (int k = 0; k <= LAT; k++) h_v[k] = 0;
        end else begin
            for (int k = LAT; k > 0; k--) begin
                h_v[k] = h_v[k-1]; h_a[k] = h_a[k-1]; h_m[k] = h_m[k-1];
            end
            h_v[0] = (m_st == 1); h_a[0] = m_ph[31:24]; h_m[0] = m_amp;
            acc = cfg_valid && !m_pend;
            m_done = 0;
            if (m_st == 0) begin
                if (m_pend) begin
                    m_freq = s_freq; m_amp = s_amp; m_cyc = s_cyc; m_pend = 0;
                end
                if (start && !stop) begin
                    m_st = 1; m_ph = 0; m_cnt = 0; m_sreq = 0;
                end
            end else if (m_st == 1) begin
                sum  = longint'(m_ph) + longint'(m_freq);
                wrap = (sum >= 64'h1_0000_0000);
                fin  = wrap && (((m_cyc != 0) && (16'(m_cnt + 16'd1) == m_cyc)) || m_sreq);
                m_ph = sum[31:0];
                if (stop) m_sreq = 1;
                if (wrap) begin
                    m_cnt = m_cnt + 16'd1;
                    if (m_pend) begin
                        m_freq = s_freq; m_amp = s_amp; m_cyc = s_cyc; m_pend = 0;
                    end
                end
                if (fin) begin
                    m_st = 2; m_ph = 0; m_left = LAT + 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_st = 0; m_done = 1; m_sreq = 0;
                end
            end
            if (acc) begin
                s_freq = cfg_freq; s_amp = cfg_amp; s_cyc = cfg_cycles; m_pend = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
`ifdef DA_WAVE_DITHER_EN
            total++;
            if (!(rd_addr === m_ph[31:24] || (m_st == 1 && rd_addr === 8'(m_ph[31:24] + 8'd1)))) begin
                bad++;
                $display("FAIL rd_addr: got %0h want %0h or +1 at %0t", rd_addr, m_ph[31:24], $time);
            end
`else
            chk("rd_addr", 32'(rd_addr), 32'(m_ph[31:24]));
`endif
            chk("busy", 32'(busy), 32'(m_st != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
            chk("da_data", 32'(da_data), h_v[LAT] ? 32'(scale(rom[h_a[LAT]], h_m[LAT])) : 32'h80);
            chk("da_clk", 32'(da_clk), 32'h1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_send(input logic [31:0] f, input logic [7:0] a, input logic [15:0] c);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 3000) begin tick(); n++; end
        if (n >= 3000) chk("cfg_ready_timeout", 32'(n), 32'(0));
        cfg_freq = f; cfg_amp = a; cfg_cycles = c; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_addr(input logic [7:0] a, input string nm);
        int n = 0;
        while (rd_addr !== a && n < 3000) begin tick(); n++; end
        if (n >= 3000) chk(nm, 32'(rd_addr), 32'(a));
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin n++; tick(); end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_da"}, 32'(da_data), 32'h80);
        chk({tag, "_addr"}, 32'(rd_addr), 32'h0);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'h1);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_freq = '0; cfg_amp = '0; cfg_cycles = '0;
        for (int i = 0; i < 256; i++) rom[i] = i[7:0];
        tick();
        chk_en = 1'b1;
        tick(2);
        chk_reset_state("por");
        rst = 1'b0;

        // continuous playback, identity ROM
        cfg_send(32'h0100_0000, 8'd255, 16'd0);
        tick(2);
        pulse_start();
        chk("run_first_addr", 32'(rd_addr), 32'h0);
        wait_addr(8'hFF, "wait_ff");
        tick(LAT + 1);
        chk("da_of_ff", 32'(da_data), 32'hFE);
        chk("cont_busy", 32'(busy), 32'h1);

        // reset held 3 cycles mid-run
        rst = 1'b1;
        tick(3);
        chk_reset_state("midrst");
        rst = 1'b0;
        tick();

        // burst of 2 periods
        cfg_send(32'h0100_0000, 8'd255, 16'd2);
        tick(2);
        pulse_start();
        count_busy(n);
        chk("burst_busy_cycles", 32'(n), 32'(512 + LAT + 1));
        chk("burst_done", 32'(done), 32'h1);
        chk("burst_da_idle", 32'(da_data), 32'h80);
        tick();
        chk("burst_done_1cyc", 32'(done), 32'h0);

        // stop at address 8'h40 finishes the period
        cfg_send(32'h0100_0000, 8'd255, 16'd0);
        tick(2);
        pulse_start();
        wait_addr(8'h40, "wait_40");
        stop = 1'b1; tick(); stop = 1'b0;
        count_busy(n);
        chk("stop_busy_cycles", 32'(n), 32'(191 + LAT + 1));
        chk("stop_done", 32'(done), 32'h1);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        tick(2);
        chk("start_stop_idle", 32'(busy), 32'h0);

        // mid-run config change, ROM all 8'hFF
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        cfg_send(32'h0100_0000, 8'd255, 16'd0);
        tick(2);
        pulse_start();
        wait_addr(8'h10, "wait_10");
        cfg_send(32'h0200_0000, 8'd128, 16'd0);
        chk("pend_ready_low", 32'(cfg_ready), 32'h0);
        wait_addr(8'hFF, "wait_ff2");
        chk("pend_ready_at_wrap", 32'(cfg_ready), 32'h0);
        chk("da_amp255_ff", 32'(da_data), 32'hFE);
        tick();
        chk("post_wrap_addr0", 32'(rd_addr), 32'h0);
        chk("ready_after_xfer", 32'(cfg_ready), 32'h1);
        tick();
        chk("post_wrap_addr2", 32'(rd_addr), 32'h2);
        tick();
        chk("post_wrap_addr4", 32'(rd_addr), 32'h4);
        tick(LAT + 1);
        chk("da_amp128_ff", 32'(da_data), 32'hBF);
        cfg_send(32'h0200_0000, 8'd0, 16'd0);
        wait_addr(8'hFE, "wait_fe");
        tick(LAT + 2);
        chk("da_amp0", 32'(da_data), 32'h80);
        chk("amp0_busy", 32'(busy), 32'h1);
        stop = 1'b1; tick(); stop = 1'b0;
        count_busy(n);
        chk("midcfg_done", 32'(done), 32'h1);

        // fine frequency: exact truncation of the phase
        for (int i = 0; i < 256; i++) rom[i] = i[7:0];
        tick(LAT + 2);
        cfg_send(32'h0000_8000, 8'd255, 16'd0);
        tick(2);
        pulse_start();
        tick(512);
`ifdef DA_WAVE_DITHER_EN
        chk("fine_addr_le2", 32'(rd_addr <= 8'd2), 32'h1);
`else
        chk("fine_addr_512", 32'(rd_addr), 32'h1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(2);
        chk_reset_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
